alu_share_ctrl: RTL and testbench

//  Sequencer/arbiter sharing the single 32-bit ALU (ADD/SUB/AND/OR, NZCV) between two

---
 rtl/alu_share_ctrl_if.sv | 30 +++
 rtl/alu_share_ctrl.sv | 67 ++++++
 tb/tb_alu_share_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: request, response and ALU signal bundle for alu_share_ctrl
// Two request ports (r0_*, r1_*), the response channel (rsp_*), the shared ALU hookup (alu_*) and busy.
// The slave modport is the sequencer's view; the master modport is the view of the surrounding logic.
interface alu_share_ctrl_if #(parameter int DATA_W = 32);
  logic              r0_valid, r0_ready;
  logic [DATA_W-1:0] r0_a, r0_b;
  logic [1:0]        r0_op;
  logic              r1_valid, r1_ready;
  logic [DATA_W-1:0] r1_a, r1_b;
  logic [1:0]        r1_op;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic [3:0]        rsp_nzcv;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [1:0]        alu_ctrl;
  logic [3:0]        alu_nzcv;
  logic              busy;
  modport slave (
    input  r0_valid, r0_a, r0_b, r0_op, r1_valid, r1_a, r1_b, r1_op,
           rsp_ready, alu_result, alu_nzcv,
    output r0_ready, r1_ready, rsp_valid, rsp_id, rsp_result, rsp_nzcv,
           alu_a, alu_b, alu_ctrl, busy
  );
  modport master (
    output r0_valid, r0_a, r0_b, r0_op, r1_valid, r1_a, r1_b, r1_op,
           rsp_ready, alu_result, alu_nzcv,
    input  r0_ready, r1_ready, rsp_valid, rsp_id, rsp_result, rsp_nzcv,
           alu_a, alu_b, alu_ctrl, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between two requesters and returns result/NZCV with the requester id
// Ports: clk, reset (sync, active-high), bus (alu_share_ctrl_if.slave: two request ports, response channel, ALU hookup, busy).
// FAIR=1 alternates grants when both ports are valid; FAIR=0 always favours port 0.
module alu_share_ctrl #(
  parameter int DATA_W = 32,
  parameter bit FAIR   = 1'b1
) (
  input logic               clk,
  input logic               reset,
  alu_share_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t            state, state_n;
  logic [DATA_W-1:0] a_q, b_q;
  logic [1:0]        op_q;
  logic              id_q, last_grant;
  logic              win, g1, acc;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic [3:0]        rsp_nzcv_q;
  // Ready depends only on state, valids and rsp_ready, never on alu_result.
  always_comb begin
    win     = state == IDLE || (state == RESP && bus.rsp_ready);
    g1      = bus.r1_valid && (!bus.r0_valid || (FAIR && !last_grant));
    acc     = win && (bus.r0_valid || bus.r1_valid);
    state_n = state == IDLE ? (acc ? EXEC : IDLE) :
              state == EXEC ? RESP :
              !bus.rsp_ready ? RESP : acc ? EXEC : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      last_grant   <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_nzcv_q   <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        a_q        <= g1 ? bus.r1_a : bus.r0_a;
        b_q        <= g1 ? bus.r1_b : bus.r0_b;
        op_q       <= g1 ? bus.r1_op : bus.r0_op;
        id_q       <= g1;
        last_grant <= g1;
      end
      if (state == EXEC) begin
        rsp_result_q <= bus.alu_result;
        rsp_nzcv_q   <= bus.alu_nzcv;
        rsp_id_q     <= id_q;
      end
    end
  end
  assign bus.r0_ready   = acc && !g1;
  assign bus.r1_ready   = acc && g1;
  assign bus.rsp_valid  = state == RESP;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_nzcv   = rsp_nzcv_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_ctrl   = op_q;
  assign bus.busy       = state != IDLE;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed bench for alu_share_ctrl (fair instance plus a fixed-priority twin)
module tb_alu_share_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  alu_share_ctrl_if #(.DATA_W(32)) bus();
  alu_share_ctrl_if #(.DATA_W(32)) fbus();
  alu_share_ctrl #(.DATA_W(32), .FAIR(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  alu_share_ctrl #(.DATA_W(32), .FAIR(1'b0)) fdut (.clk(clk), .reset(reset), .bus(fbus.slave));
  always #5 clk = ~clk;
  assign fbus.r0_valid  = bus.r0_valid;
  assign fbus.r0_a      = bus.r0_a;
  assign fbus.r0_b      = bus.r0_b;
  assign fbus.r0_op     = bus.r0_op;
  assign fbus.r1_valid  = bus.r1_valid;
  assign fbus.r1_a      = bus.r1_a;
  assign fbus.r1_b      = bus.r1_b;
  assign fbus.r1_op     = bus.r1_op;
  assign fbus.rsp_ready = bus.rsp_ready;
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = op == 2'b01 ? {1'b0, a} + {1'b0, ~b} + 33'd1 : {1'b0, a} + {1'b0, b};
    r = op == 2'b10 ? a & b : op == 2'b11 ? a | b : s[31:0];
    c = op[1] ? 1'b0 : s[32];
    v = op == 2'b00 ? (a[31] == b[31]) && (r[31] != a[31]) :
        op == 2'b01 ? (a[31] != b[31]) && (r[31] != a[31]) : 1'b0;
    return {r[31], r == 32'd0, c, v, r};
  endfunction
  always_comb {bus.alu_nzcv, bus.alu_result}   = alu_f(bus.alu_a, bus.alu_b, bus.alu_ctrl);
  always_comb {fbus.alu_nzcv, fbus.alu_result} = alu_f(fbus.alu_a, fbus.alu_b, fbus.alu_ctrl);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic op1(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                     input logic [31:0] er, input logic [3:0] en);
    bus.r0_valid = 1'b1;
    bus.r0_a = a;
    bus.r0_b = b;
    bus.r0_op = op;
    @(negedge clk);
    check({tag, "_r0_ready"}, 32'(bus.r0_ready), 32'd1);
    step();
    bus.r0_valid = 1'b0;
    @(negedge clk);
    check({tag, "_exec_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_exec_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_alu_a"}, bus.alu_a, a);
    step();
    @(negedge clk);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_result"}, bus.rsp_result, er);
    check({tag, "_nzcv"}, 32'(bus.rsp_nzcv), 32'(en));
    check({tag, "_id"}, 32'(bus.rsp_id), 32'd0);
    step();
  endtask
  int r1_hits, fair_n, fix_n, stray;
  logic grants [4];
  initial begin
    reset = 1'b1;
    bus.r0_valid = 1'b0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_op = '0;
    bus.r1_valid = 1'b0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_op = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", bus.rsp_result, 32'd0);
    check("rst_nzcv", 32'(bus.rsp_nzcv), 32'd0);
    check("rst_alu", {bus.alu_a[15:0], bus.alu_b[13:0], bus.alu_ctrl}, 32'd0);
    step();
    reset = 1'b0;
    op1("add", 32'd5, 32'd7, 2'b00, 32'd12, 4'b0000);
    // both ports after reset: port 0 first, port 1 accepted on the response handshake
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.r0_valid = 1'b1; bus.r0_a = 32'd3; bus.r0_b = 32'd5; bus.r0_op = 2'b01;
    bus.r1_valid = 1'b1; bus.r1_a = 32'd6; bus.r1_b = 32'd3; bus.r1_op = 2'b10;
    @(negedge clk);
    check("arb_r0_ready", 32'(bus.r0_ready), 32'd1);
    check("arb_r1_ready", 32'(bus.r1_ready), 32'd0);
    step();
    bus.r0_valid = 1'b0;
    @(negedge clk);
    check("arb_exec_r1_ready", 32'(bus.r1_ready), 32'd0);
    step();
    @(negedge clk);
    check("arb_rsp0_result", bus.rsp_result, 32'hFFFF_FFFE);
    check("arb_rsp0_nzcv", 32'(bus.rsp_nzcv), 32'h8);
    check("arb_rsp0_id", 32'(bus.rsp_id), 32'd0);
    check("arb_r1_same_cycle", 32'(bus.r1_ready), 32'd1);
    step();
    bus.r1_valid = 1'b0;
    step();
    @(negedge clk);
    check("arb_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
    check("arb_rsp1_result", bus.rsp_result, 32'd2);
    check("arb_rsp1_id", 32'(bus.rsp_id), 32'd1);
    check("arb_rsp1_nzcv", 32'(bus.rsp_nzcv), 32'd0);
    step();
    @(negedge clk);
    check("arb_idle_busy", 32'(bus.busy), 32'd0);
    // backpressure: response held while r1 waits
    bus.rsp_ready = 1'b0;
    bus.r0_valid = 1'b1; bus.r0_a = 32'd10; bus.r0_b = 32'd4; bus.r0_op = 2'b01;
    step();
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b1; bus.r1_a = 32'd7; bus.r1_b = 32'd8; bus.r1_op = 2'b11;
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_result", bus.rsp_result, 32'd6);
      check("bp_nzcv", 32'(bus.rsp_nzcv), 32'h2);
      check("bp_r1_ready", 32'(bus.r1_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_r1_ready", 32'(bus.r1_ready), 32'd1);
    check("bp_release_result", bus.rsp_result, 32'd6);
    step();
    bus.r1_valid = 1'b0;
    @(negedge clk);
    check("bp_exec_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    @(negedge clk);
    check("bp_rsp1_result", bus.rsp_result, 32'd15);
    check("bp_rsp1_id", 32'(bus.rsp_id), 32'd1);
    step();
    // flag corner cases
    op1("ovf", 32'h7FFF_FFFF, 32'd1, 2'b00, 32'h8000_0000, 4'b1001);
    op1("wrap", 32'hFFFF_FFFF, 32'd1, 2'b00, 32'd0, 4'b0110);
    op1("sub0", 32'd5, 32'd5, 2'b01, 32'd0, 4'b0110);
    // reset while in EXEC
    bus.r0_valid = 1'b1; bus.r0_a = 32'd1; bus.r0_b = 32'd2; bus.r0_op = 2'b00;
    step();
    bus.r0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rx_exec_busy", 32'(bus.busy), 32'd1);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rx_busy", 32'(bus.busy), 32'd0);
    check("rx_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rx_alu_a", bus.alu_a, 32'd0);
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      if (bus.rsp_valid) stray++;
    end
    check("rx_no_rsp", 32'(stray), 32'd0);
    // saturation: fair alternates, fixed never serves port 1
    step();
    bus.r0_valid = 1'b1; bus.r0_a = 32'd1; bus.r0_b = 32'd1; bus.r0_op = 2'b00;
    bus.r1_valid = 1'b1; bus.r1_a = 32'd2; bus.r1_b = 32'd2; bus.r1_op = 2'b00;
    r1_hits = 0; fair_n = 0; fix_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fbus.r1_ready) r1_hits++;
      if (fbus.r0_ready) fix_n++;
      if (bus.r0_ready || bus.r1_ready) begin
        if (fair_n < 4) grants[fair_n] = bus.r1_ready;
        fair_n++;
      end
      step();
    end
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    check("fix_r1_ready", 32'(r1_hits), 32'd0);
    check("fix_grants", 32'(fix_n), 32'd10);
    check("fair_grants", 32'(fair_n), 32'd10);
    check("fair_order", {28'd0, grants[0], grants[1], grants[2], grants[3]}, 32'b0101);
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
